// File: rtl/sha256_compress_if.sv
// sha256_compress_if: command/result bundle between the hash controller and the compression engine
interface sha256_compress_if;
    logic         start;
    logic         init_message;
    logic         init_iv;
    logic [511:0] data_in;
    logic [255:0] data_out;
    logic         data_out_valid;
    logic         done;
    logic         busy;
    modport master (output start, init_message, init_iv, data_in,
                    input  data_out, data_out_valid, done, busy);
    modport slave  (input  start, init_message, init_iv, data_in,
                    output data_out, data_out_valid, done, busy);
endinterface

// File: rtl/sha256_compress.sv
// sha256_compress: iterative one-round-per-clock SHA-256 block compression with internal chaining
module sha256_compress (
    input logic              clk,
    input logic              reset,
    sha256_compress_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    state_t            r_state;
    logic [511:0]      r_msg;
    logic [0:15][31:0] r_w;
    logic [0:7][31:0]  r_h;
    logic [0:7][31:0]  r_v;
    logic [5:0]        r_t;
    logic              r_use_iv;
    logic              r_done;
    logic              r_valid;
    logic              r_busy;
    logic [0:7][31:0]  w_sum;
    logic [511:0]      w_blk;
    logic [31:0]       w_t1;
    logic [31:0]       w_t2;
    logic [31:0]       w_wnew;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    always_comb begin
        w_t1 = r_v[7] + (rotr(r_v[4], 6) ^ rotr(r_v[4], 11) ^ rotr(r_v[4], 25))
             + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6])) + K[r_t] + r_w[0];
        w_t2 = (rotr(r_v[0], 2) ^ rotr(r_v[0], 13) ^ rotr(r_v[0], 22))
             + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
        w_wnew = (rotr(r_w[14], 17) ^ rotr(r_w[14], 19) ^ (r_w[14] >> 10)) + r_w[9]
               + (rotr(r_w[1], 7) ^ rotr(r_w[1], 18) ^ (r_w[1] >> 3)) + r_w[0];
        w_blk = bus.init_message ? bus.data_in : r_msg;
        w_sum = '0;
        // IV feed-forward comes from the constant so H keeps the previous digest visible
        for (int i = 0; i < 8; i++)
            w_sum[i] = (r_use_iv ? IV[i] : r_h[i]) + r_v[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_msg    <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_v      <= '0;
            r_t      <= '0;
            r_use_iv <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.init_message)
                        r_msg <= bus.data_in;
                    if (bus.start) begin
                        r_w      <= w_blk;
                        r_v      <= bus.init_iv ? IV : r_h;
                        r_use_iv <= bus.init_iv;
                        r_t      <= '0;
                        r_busy   <= 1'b1;
                        r_valid  <= 1'b0;
                        r_state  <= ROUND;
                    end
                end
                ROUND: begin
                    r_v <= {w_t1 + w_t2, r_v[0], r_v[1], r_v[2], r_v[3] + w_t1, r_v[4], r_v[5], r_v[6]};
                    r_w <= {r_w[1:15], w_wnew};
                    r_t <= r_t + 6'd1;
                    if (r_t == 6'd63)
                        r_state <= FINAL;
                end
                FINAL: begin
                    r_h     <= w_sum;
                    r_done  <= 1'b1;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.data_out       = r_h;
    assign bus.data_out_valid = r_valid;
    assign bus.done           = r_done;
    assign bus.busy           = r_busy;
endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: randomized scoreboard bench for sha256_compress against a FIPS-style reference model
module tb_sha256_compress;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sha256_compress_if bus ();
    sha256_compress dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [255:0] IV_W = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [511:0] ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B2 = {{15{32'h0}}, 32'h000001c0};
    localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    int checks = 0;
    int errors = 0;
    logic [255:0] exp_q [$];
    logic [255:0] m_h = '0;
    logic [255:0] m_prev = '0;
    logic [511:0] m_msg = '0;
    logic [255:0] mon_exp;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression: full 64-entry schedule array, then 64 rounds, then feed-forward
    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                mon_exp = exp_q.pop_front();
                chk("scoreboard_digest", bus.data_out, mon_exp);
            end
        end
    end

    // Drive a start now; the next rising edge is the start edge
    task automatic issue(input logic [511:0] blk, input logic im, input logic iv);
        bus.start = 1'b1;
        bus.init_message = im;
        bus.init_iv = iv;
        bus.data_in = blk;
        if (im) m_msg = blk;
        m_prev = m_h;
        m_h = ref_compress(iv ? IV_W : m_h, m_msg);
        exp_q.push_back(m_h);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.init_message = 1'b0;
        bus.init_iv = 1'($urandom);
        bus.data_in = rand512();
    endtask

    task automatic start_blk(input logic [511:0] blk, input logic im, input logic iv);
        @(posedge clk);
        #1;
        issue(blk, im, iv);
    endtask

    task automatic wait_done(input int pulse_at);
        int n = 0;
        int nb = 0;
        int bad_valid = 0;
        int bad_out = 0;
        forever begin
            @(negedge clk);
            if (bus.done || n == 200) break;
            n++;
            if (bus.busy) nb++;
            if (bus.data_out_valid) bad_valid++;
            if (bus.data_out !== m_prev) bad_out++;
            if (n == pulse_at) begin
                bus.start = 1'b1;
                bus.init_message = 1'b1;
                bus.init_iv = ~bus.init_iv;
                bus.data_in = rand512();
            end else if (n == pulse_at + 1) begin
                bus.start = 1'b0;
                bus.init_message = 1'b0;
            end
        end
        chk("latency", 256'(n), 256'd65);
        chk("busy_cycles", 256'(nb), 256'd65);
        chk("valid_low_while_busy", 256'(bad_valid), 256'd0);
        chk("data_out_stable", 256'(bad_out), 256'd0);
        chk("done_cycle_status", {253'd0, bus.busy, bus.data_out_valid, bus.done}, 256'b011);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.init_message = 1'b0;
        bus.init_iv = 1'b0;
        bus.data_in = '0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data_out", bus.data_out, 256'd0);
        chk("reset_status", {253'd0, bus.data_out_valid, bus.done, bus.busy}, 256'd0);
        reset = 1'b1;

        start_blk(rand512(), 1'b1, 1'b0);
        wait_done(-1);

        start_blk(ABC, 1'b1, 1'b1);
        wait_done(-1);
        chk("abc_digest", bus.data_out, D_ABC);

        start_blk(EMPTY, 1'b1, 1'b1);
        wait_done(-1);
        chk("empty_digest", bus.data_out, D_EMPTY);

        start_blk(B1, 1'b1, 1'b1);
        wait_done(-1);
        issue(B2, 1'b1, 1'b0);
        wait_done(-1);
        chk("two_block_digest", bus.data_out, D_TWO);

        start_blk(ABC, 1'b1, 1'b1);
        wait_done(20);
        chk("busy_pulse_ignored", bus.data_out, D_ABC);
        start_blk(rand512(), 1'b0, 1'b1);
        wait_done(-1);
        chk("reuse_latched_msg", bus.data_out, D_ABC);

        start_blk(EMPTY, 1'b1, 1'b1);
        repeat (31) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midreset_data_out", bus.data_out, 256'd0);
        chk("midreset_status", {253'd0, bus.data_out_valid, bus.done, bus.busy}, 256'd0);
        exp_q.delete();
        m_h = '0;
        m_msg = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (80) @(negedge clk);
        chk("no_resume_after_reset", {255'd0, bus.busy}, 256'd0);
        start_blk(ABC, 1'b1, 1'b1);
        wait_done(-1);
        chk("abc_after_reset", bus.data_out, D_ABC);

        start_blk(EMPTY, 1'b1, 1'b1);
        wait_done(-1);
        @(posedge clk);
        #1;
        bus.init_message = 1'b1;
        bus.data_in = ABC;
        m_msg = ABC;
        @(posedge clk);
        #1;
        bus.init_message = 1'b0;
        bus.data_in = rand512();
        repeat (1) @(posedge clk);
        #1;
        issue(rand512(), 1'b0, 1'b1);
        wait_done(-1);
        chk("separate_load_digest", bus.data_out, D_ABC);

        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1)
                issue(rand512(), 1'($urandom), 1'($urandom));
            else
                start_blk(rand512(), 1'($urandom), 1'($urandom));
            wait_done(k == 3 ? 40 : -1);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
